// File: rtl/ram_port_arbiter_if.sv
// Handshake and RAM-pin bundle for ram_port_arbiter.
// "master" is the environment: both requesters plus the RAM read-data pin.
// "slave" is the arbiter itself.
interface ram_port_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    // Requester A
    logic                  req_a;
    logic                  wr_a;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [DATA_WIDTH-1:0] wdata_a;
    logic                  ack_a;

    // Requester B
    logic                  req_b;
    logic                  wr_b;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [DATA_WIDTH-1:0] wdata_b;
    logic                  ack_b;

    // Shared results
    logic [DATA_WIDTH-1:0] rdata;
    logic                  busy;

    // RAM port pins
    logic [ADDR_WIDTH-1:0] ram_address;
    logic                  ram_cs;
    logic                  ram_we;
    logic                  ram_oe;
    logic [DATA_WIDTH-1:0] ram_dout;
    logic                  ram_dout_en;
    logic [DATA_WIDTH-1:0] ram_din;

    modport master (
        output req_a, wr_a, addr_a, wdata_a,
        output req_b, wr_b, addr_b, wdata_b,
        output ram_din,
        input  ack_a, ack_b, rdata, busy,
        input  ram_address, ram_cs, ram_we, ram_oe, ram_dout, ram_dout_en
    );

    modport slave (
        input  req_a, wr_a, addr_a, wdata_a,
        input  req_b, wr_b, addr_b, wdata_b,
        input  ram_din,
        output ack_a, ack_b, rdata, busy,
        output ram_address, ram_cs, ram_we, ram_oe, ram_dout, ram_dout_en
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter and strobe sequencer sharing one asynchronous RAM port
// between requesters A and B. Each transaction runs
// IDLE -> SETUP -> ACCESS (ACCESS_CYCLES cycles) -> RELEASE -> IDLE.
// Every output is a register whose next value is derived from the state
// being entered, so the RAM pins never glitch.
// ACCESS_CYCLES must lie in 1..15 (it loads a 4-bit down-counter).
module ram_port_arbiter #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 8,
    parameter int ACCESS_CYCLES = 2
) (
    input logic             clk,
    input logic             reset,
    ram_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        ACCESS  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);
    localparam logic       SEL_A    = 1'b0;
    localparam logic       SEL_B    = 1'b1;

    // Control state
    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic       last, last_nx;
    logic       gnt, gnt_nx;

    // Fields of the granted requester, frozen at the grant edge
    logic                  wr_l, wr_nx;
    logic [ADDR_WIDTH-1:0] addr_l, addr_nx;
    logic [DATA_WIDTH-1:0] wdata_l, wdata_nx;

    // Registered outputs and their next values
    logic                  ack_a_q, ack_a_nx;
    logic                  ack_b_q, ack_b_nx;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_nx;
    logic                  busy_q, busy_nx;
    logic [ADDR_WIDTH-1:0] address_q, address_nx;
    logic                  cs_q, cs_nx;
    logic                  we_q, we_nx;
    logic                  oe_q, oe_nx;
    logic [DATA_WIDTH-1:0] dout_q, dout_nx;
    logic                  dout_en_q, dout_en_nx;
    logic                  active;

    // Next-state, arbitration and next registered-output values
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        last_nx  = last;
        gnt_nx   = gnt;
        wr_nx    = wr_l;
        addr_nx  = addr_l;
        wdata_nx = wdata_l;
        rdata_nx = rdata_q;

        case (state)
            IDLE: begin
                // A wins a tie only when B was served last
                if (bus.req_a && (!bus.req_b || last == SEL_B)) begin
                    gnt_nx   = SEL_A;
                    last_nx  = SEL_A;
                    wr_nx    = bus.wr_a;
                    addr_nx  = bus.addr_a;
                    wdata_nx = bus.wdata_a;
                    state_nx = SETUP;
                end else if (bus.req_b) begin
                    gnt_nx   = SEL_B;
                    last_nx  = SEL_B;
                    wr_nx    = bus.wr_b;
                    addr_nx  = bus.addr_b;
                    wdata_nx = bus.wdata_b;
                    state_nx = SETUP;
                end
            end
            SETUP: begin
                cnt_nx   = CNT_LOAD;
                state_nx = ACCESS;
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    state_nx = RELEASE;
                    // RAM output is still enabled on this edge
                    if (!wr_l) begin
                        rdata_nx = bus.ram_din;
                    end
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            RELEASE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // Outputs describe the state about to be entered
        active     = (state_nx != IDLE);
        busy_nx    = active;
        cs_nx      = active;
        address_nx = active ? addr_nx : '0;
        dout_en_nx = active && wr_nx;
        dout_nx    = dout_en_nx ? wdata_nx : '0;
        we_nx      = (state_nx == ACCESS) && wr_nx;
        oe_nx      = (state_nx == ACCESS) && !wr_nx;
        ack_a_nx   = (state_nx == RELEASE) && (gnt_nx == SEL_A);
        ack_b_nx   = (state_nx == RELEASE) && (gnt_nx == SEL_B);
    end

    // Control state and output registers; reset aborts any transaction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            last      <= SEL_B;
            gnt       <= SEL_A;
            ack_a_q   <= 1'b0;
            ack_b_q   <= 1'b0;
            rdata_q   <= '0;
            busy_q    <= 1'b0;
            address_q <= '0;
            cs_q      <= 1'b0;
            we_q      <= 1'b0;
            oe_q      <= 1'b0;
            dout_q    <= '0;
            dout_en_q <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            last      <= last_nx;
            gnt       <= gnt_nx;
            ack_a_q   <= ack_a_nx;
            ack_b_q   <= ack_b_nx;
            rdata_q   <= rdata_nx;
            busy_q    <= busy_nx;
            address_q <= address_nx;
            cs_q      <= cs_nx;
            we_q      <= we_nx;
            oe_q      <= oe_nx;
            dout_q    <= dout_nx;
            dout_en_q <= dout_en_nx;
        end
    end

    // Latched request fields; only consumed while a grant is active
    always_ff @(posedge clk) begin
        wr_l    <= wr_nx;
        addr_l  <= addr_nx;
        wdata_l <= wdata_nx;
    end

    assign bus.ack_a       = ack_a_q;
    assign bus.ack_b       = ack_b_q;
    assign bus.rdata       = rdata_q;
    assign bus.busy        = busy_q;
    assign bus.ram_address = address_q;
    assign bus.ram_cs      = cs_q;
    assign bus.ram_we      = we_q;
    assign bus.ram_oe      = oe_q;
    assign bus.ram_dout    = dout_q;
    assign bus.ram_dout_en = dout_en_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: three instances (ACCESS_CYCLES = 2, 1, 15),
// each attached to a simple asynchronous RAM model, driven by directed and
// random transactions and compared with a transaction-level reference.
module tb_ram_port_arbiter;
    localparam int DW = 8;
    localparam int AW = 8;
    localparam int N  = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [N-1:0]  req_a, req_b, wr_a, wr_b;
    logic [AW-1:0] addr_a [N];
    logic [AW-1:0] addr_b [N];
    logic [DW-1:0] wdata_a [N];
    logic [DW-1:0] wdata_b [N];
    logic [N-1:0]  ack_a, ack_b, busy, cs, we, oe, den;
    logic [DW-1:0] rdata [N];
    logic [DW-1:0] dout [N];
    logic [AW-1:0] raddr [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int AC = (g == 0) ? 2 : (g == 1) ? 1 : 15;
        ram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
        logic [DW-1:0] mem [256];

        assign bus.req_a   = req_a[g];
        assign bus.wr_a    = wr_a[g];
        assign bus.addr_a  = addr_a[g];
        assign bus.wdata_a = wdata_a[g];
        assign bus.req_b   = req_b[g];
        assign bus.wr_b    = wr_b[g];
        assign bus.addr_b  = addr_b[g];
        assign bus.wdata_b = wdata_b[g];
        assign ack_a[g]    = bus.ack_a;
        assign ack_b[g]    = bus.ack_b;
        assign rdata[g]    = bus.rdata;
        assign busy[g]     = bus.busy;
        assign cs[g]       = bus.ram_cs;
        assign we[g]       = bus.ram_we;
        assign oe[g]       = bus.ram_oe;
        assign den[g]      = bus.ram_dout_en;
        assign dout[g]     = bus.ram_dout;
        assign raddr[g]    = bus.ram_address;

        // asynchronous RAM: output driven while selected and enabled
        assign bus.ram_din = (bus.ram_cs && bus.ram_oe) ? mem[bus.ram_address] : '0;
        always @(posedge clk) if (bus.ram_cs && bus.ram_we) mem[bus.ram_address] <= bus.ram_dout;

        ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ACCESS_CYCLES(AC)) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus)
        );
    end

    // reference model state
    logic [DW-1:0] ref_mem [N][256];
    bit            ref_wr  [N][256];
    logic [DW-1:0] ref_rdata [N];
    bit            ref_last [N];     // 1 = B served last

    int vectors = 0;
    int miscompares = 0;

    function automatic int ac_of(input int k);
        return (k == 0) ? 2 : (k == 1) ? 1 : 15;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic all_zero_chk(input int k, input string tag);
        chk(tag, {1'b0, ack_a[k], ack_b[k], busy[k], cs[k], we[k], oe[k], den[k],
                  rdata[k], raddr[k], dout[k]}, 32'h0);
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            ref_last[k]  = 1'b1;
            ref_rdata[k] = '0;
        end
    endtask

    // apply one completed transaction to the model and check rdata seen at ack
    task automatic apply(input int k, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] got, input string tag);
        if (wr) begin
            ref_mem[k][a] = d;
            ref_wr[k][a]  = 1'b1;
        end else begin
            ref_rdata[k] = ref_mem[k][a];
        end
        chk({tag, "_rdata"}, {24'h0, got}, {24'h0, ref_rdata[k]});
    endtask

    // single transaction from one requester, other requester idle
    task automatic txn(input int k, input bit pb, input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input string tag);
        int cyc, we_n, oe_n, cs_n, den_n, viol, bad, other;
        bit got;
        logic [DW-1:0] rd;
        int ac;
        ac = ac_of(k);
        cyc = 0; we_n = 0; oe_n = 0; cs_n = 0; den_n = 0; viol = 0; bad = 0; other = 0;
        got = 0; rd = '0;
        @(negedge clk);
        if (!pb) begin req_a[k] = 1; wr_a[k] = wr; addr_a[k] = a; wdata_a[k] = d; end
        else     begin req_b[k] = 1; wr_b[k] = wr; addr_b[k] = a; wdata_b[k] = d; end
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                // fields changed after the grant must be ignored
                if (!pb) begin wr_a[k] = ~wr; addr_a[k] = ~a; wdata_a[k] = ~d; end
                else     begin wr_b[k] = ~wr; addr_b[k] = ~a; wdata_b[k] = ~d; end
            end
            we_n += int'(we[k]); oe_n += int'(oe[k]); cs_n += int'(cs[k]); den_n += int'(den[k]);
            if (we[k] && oe[k]) viol++;
            if (oe[k] && den[k]) viol++;
            if (cs[k] && raddr[k] !== a) bad++;
            if (den[k] && dout[k] !== d) bad++;
            if (pb ? ack_a[k] : ack_b[k]) other++;
            if (pb ? ack_b[k] : ack_a[k]) begin got = 1; rd = rdata[k]; end
        end
        if (!pb) req_a[k] = 0; else req_b[k] = 0;
        chk({tag, "_ack_seen"}, {31'h0, got}, 32'h1);
        chk({tag, "_latency"}, cyc, ac + 2);
        chk({tag, "_we_width"}, we_n, wr ? ac : 0);
        chk({tag, "_oe_width"}, oe_n, wr ? 0 : ac);
        chk({tag, "_cs_width"}, cs_n, ac + 2);
        chk({tag, "_dout_en"}, den_n, wr ? ac + 2 : 0);
        chk({tag, "_strobe_excl"}, viol, 0);
        chk({tag, "_pins"}, bad, 0);
        chk({tag, "_other_ack"}, other, 0);
        apply(k, wr, a, d, rd, tag);
        ref_last[k] = pb;
    endtask

    // both requesters raise req on the same cycle
    task automatic pair(input int k, input bit wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                        input bit wb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
                        input string tag);
        int cyc, ta, tb, viol, ac, t1, t2;
        logic [DW-1:0] rda, rdb;
        bit first_b;
        ac = ac_of(k);
        cyc = 0; ta = -1; tb = -1; viol = 0; rda = '0; rdb = '0;
        @(negedge clk);
        req_a[k] = 1; wr_a[k] = wa; addr_a[k] = aa; wdata_a[k] = da;
        req_b[k] = 1; wr_b[k] = wb; addr_b[k] = ab; wdata_b[k] = db;
        while ((ta < 0 || tb < 0) && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (we[k] && oe[k]) viol++;
            if (oe[k] && den[k]) viol++;
            if (ack_a[k]) begin if (ta < 0) ta = cyc; else viol++; rda = rdata[k]; req_a[k] = 0; end
            if (ack_b[k]) begin if (tb < 0) tb = cyc; else viol++; rdb = rdata[k]; req_b[k] = 0; end
        end
        req_a[k] = 0; req_b[k] = 0;
        first_b = ~ref_last[k];
        t1 = ac + 2;
        t2 = t1 + ac + 3;
        chk({tag, "_ack_a_at"}, ta, first_b ? t2 : t1);
        chk({tag, "_ack_b_at"}, tb, first_b ? t1 : t2);
        chk({tag, "_protocol"}, viol, 0);
        if (!first_b) begin
            apply(k, wa, aa, da, rda, {tag, "_A"});
            apply(k, wb, ab, db, rdb, {tag, "_B"});
            ref_last[k] = 1'b1;
        end else begin
            apply(k, wb, ab, db, rdb, {tag, "_B"});
            apply(k, wa, aa, da, rda, {tag, "_A"});
            ref_last[k] = 1'b0;
        end
    endtask

    initial begin
        logic [AW-1:0] ra, rb;
        bit wa, wb, p;
        int k;
        reset = 1'b0;
        req_a = '0; req_b = '0; wr_a = '0; wr_b = '0;
        for (int i = 0; i < N; i++) begin
            addr_a[i] = '0; addr_b[i] = '0; wdata_a[i] = '0; wdata_b[i] = '0;
        end
        model_reset();

        // asynchronous reset mid-cycle: outputs clear before any clock edge
        #3 reset = 1'b1;
        #1;
        for (int i = 0; i < N; i++) all_zero_chk(i, $sformatf("reset_async_%0d", i));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // simultaneous writes from reset: A first, B five cycles later
        pair(0, 1'b1, 8'h01, 8'h11, 1'b1, 8'h02, 8'h22, "tie_from_reset");
        txn(0, 1'b0, 1'b0, 8'h01, 8'h00, "readback_a");
        chk("readback_a_value", {24'h0, rdata[0]}, 32'h11);
        txn(0, 1'b1, 1'b0, 8'h02, 8'h00, "readback_b");
        chk("readback_b_value", {24'h0, rdata[0]}, 32'h22);

        // fairness: three contended rounds alternate A,B,A,B,A,B
        for (int r = 0; r < 3; r++) begin
            ra = 8'($urandom_range(0, 15)); rb = 8'($urandom_range(16, 31));
            wa = 1'($urandom); wb = 1'($urandom);
            if (!ref_wr[0][ra]) wa = 1'b1;
            if (!ref_wr[0][rb]) wb = 1'b1;
            pair(0, wa, ra, 8'($urandom), wb, rb, 8'($urandom), $sformatf("fair_%0d", r));
        end

        // single write then read by A
        txn(0, 1'b0, 1'b1, 8'h3C, 8'hA5, "write_3c");
        txn(0, 1'b0, 1'b0, 8'h3C, 8'h00, "read_3c");
        chk("read_3c_value", {24'h0, rdata[0]}, 32'hA5);

        // reset during B's write strobe
        @(negedge clk);
        req_b[0] = 1; wr_b[0] = 1; addr_b[0] = 8'h55; wdata_b[0] = 8'h77;
        @(negedge clk);
        @(negedge clk);
        chk("abort_we_high", {31'h0, we[0]}, 32'h1);
        #2 reset = 1'b1;
        req_b[0] = 0;
        #1 all_zero_chk(0, "abort_outputs");
        @(negedge clk);
        chk("abort_no_ack_b", {31'h0, ack_b[0]}, 32'h0);
        reset = 1'b0;
        model_reset();
        pair(0, 1'b1, 8'h56, 8'h99, 1'b1, 8'h57, 8'h66, "tie_after_abort");

        // parameter sweep: ACCESS_CYCLES = 1 and 15
        for (int i = 1; i < N; i++) begin
            txn(i, 1'b0, 1'b1, 8'h10, 8'h5A, $sformatf("sweep%0d_wr", i));
            txn(i, 1'b1, 1'b0, 8'h10, 8'h00, $sformatf("sweep%0d_rd", i));
            pair(i, 1'b1, 8'h20, 8'hC3, 1'b0, 8'h10, 8'h00, $sformatf("sweep%0d_pair", i));
        end

        // random single transactions across all instances
        for (int r = 0; r < 24; r++) begin
            k  = $urandom_range(0, N - 1);
            p  = 1'($urandom);
            wa = 1'($urandom);
            ra = 8'($urandom_range(0, 15));
            if (!ref_wr[k][ra]) wa = 1'b1;
            txn(k, p, wa, ra, 8'($urandom), $sformatf("rand_%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Round-robin arbiter and access sequencer that shares one port of the dual-port asynchronous RAM between two requesters (A and B). It converts a synchronous request/acknowledge handshake into a glitch-free RAM strobe sequence. Address and data are set up one cycle before the strobe, the strobe is held for a programmable number of cycles, and the RAM signals are released one cycle later. Instantiated next to the RAM; the top level builds the tristate on the RAM data pin from `ram_dout` and `ram_dout_en`.

## Interface

Parameters:
- `DATA_WIDTH`, 8, RAM word width.
- `ADDR_WIDTH`, 8, RAM address width.
- `ACCESS_CYCLES`, 2, cycles that `ram_we` or `ram_oe` stays high. Legal range is 1..15; 0 is illegal.

Ports:
- Clocking: one clock; reset is asynchronous and active-high.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_a` / `req_b`  in  1  request from requester A / B.
- `wr_a` / `wr_b`  in  1  1 = write, 0 = read.
- `addr_a` / `addr_b`  in  ADDR_WIDTH  word address.
- `wdata_a` / `wdata_b`  in  DATA_WIDTH  write data.
- `ack_a` / `ack_b`  out  1  one-cycle pulse marking completion of that requester's transaction.
- `rdata`  out  DATA_WIDTH  read data; valid when an ack for a read is high.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `ram_address`  out  ADDR_WIDTH  to the RAM address pin.
- `ram_cs`, `ram_we`, `ram_oe`  out  1  to the RAM chip-select, write-enable and output-enable pins.
- `ram_dout`  out  DATA_WIDTH  write data toward the RAM.
- `ram_dout_en`  out  1  tristate enable for `ram_dout`.
- `ram_din`  in  DATA_WIDTH  data read back from the RAM pin.

## Operation

- FSM states: IDLE, SETUP, ACCESS, RELEASE. All outputs are registered.
- **IDLE**
  - If no request is pending, stay in IDLE with all RAM outputs at 0.
  - If one request is pending, grant it.
  - If both are pending, grant the requester not served last. Pointer `last` resets to B, so A wins the first tie.
  - On grant: latch `wr`, `addr` and `wdata` of the winner; update `last`; go to SETUP.
- **SETUP** (1 cycle)
  - `ram_cs`=1; `ram_address`=latched address.
  - For a write: `ram_dout`=latched data and `ram_dout_en`=1.
  - `ram_we`=`ram_oe`=0.
- **ACCESS** (ACCESS_CYCLES cycles)
  - `ram_cs`, `ram_address`, `ram_dout` and `ram_dout_en` are held.
  - Write: `ram_we`=1. Read: `ram_oe`=1.
  - A 4-bit down-counter is loaded with ACCESS_CYCLES-1 on entry. Exit when it reaches 0.
  - For a read, `rdata` captures `ram_din` on the exit edge.
- **RELEASE** (1 cycle)
  - `ram_we`=`ram_oe`=0, while `ram_cs`, `ram_address`, `ram_dout` and `ram_dout_en` are held (hold time).
  - `ack` of the granted requester is 1.
  - Next state is IDLE, where all RAM outputs return to 0.
- `ram_we` and `ram_oe` are never high together. `ram_dout_en` is never high during a read.
- Requests sampled while `busy` is high wait. A losing requester keeps `req` high and is served next.
- Requester rules:
  - Hold `req` high until `ack`.
  - Drop `req` the cycle after `ack`; `req` still high in IDLE is treated as a new transaction.
  - Field changes after the grant edge are ignored (fields are latched).
- `rdata` holds its value until the next read completes. Writes do not change it.
- The RAM's second port is not driven by this block.

## Timing

- Reset (asynchronous, any state):
  - FSM goes to IDLE; `last`=B.
  - All outputs go to 0, including `ack_a`, `ack_b`, `rdata`, `busy` and every `ram_*` signal.
  - An in-flight transaction is aborted with no ack; the requester must re-request.
- Latency, request sampled in IDLE at edge E:
  - SETUP occupies cycle E+1.
  - ACCESS occupies cycles E+2 .. E+1+ACCESS_CYCLES.
  - RELEASE (ack high) occurs at cycle E+2+ACCESS_CYCLES.
- Throughput: back-to-back transactions take ACCESS_CYCLES+3 cycles each. The next grant edge is the edge ending RELEASE+1 (IDLE is 1 cycle minimum).
- `busy` rises at E+1 and falls on entry to IDLE.
- `ram_cs` is high for exactly ACCESS_CYCLES+2 cycles per transaction.

## Test plan

- **Reset values:** assert `reset` asynchronously mid-cycle → all outputs 0 immediately; FSM in IDLE.
- **Single write then read, A, ACCESS_CYCLES=2:**
  - Write addr 0x3C, data 0xA5 → `ram_we` high for exactly 2 cycles; `ack_a` pulse 4 cycles after the sampling edge.
  - Read addr 0x3C → `rdata`=0xA5 with `ack_a`; `ram_dout_en` stays 0 throughout the read.
- **Simultaneous requests from reset:** A writes 0x11→addr 1, B writes 0x22→addr 2 → A served first, B immediately after. Read-back gives 0x11 / 0x22. Ack spacing is 5 cycles.
- **Fairness under contention:** both requesters continuously re-request for 6 transactions → grants alternate A,B,A,B,A,B; neither is starved.
- **Reset mid-ACCESS:** reset asserted during B's write strobe → no `ack_b`; RAM outputs 0. After reset, A and B tie → A granted first.
- **Parameter sweep:** ACCESS_CYCLES=1 and 15 → strobe width matches the parameter; ack latency equals ACCESS_CYCLES+2; `ram_we` and `ram_oe` are never simultaneously high (assertion).
